// File: rtl/bram_rmw_requester.sv
// ----------------------------------------------------------------------------
// bram_rmw_requester
// Requester-side port of one diffusion PE towards a dual-port bank scheduler.
// Residual-update requests {addr, delta} are queued, and each one becomes a
// read-modify-write on the BRAM: read the word, add delta, write it back.
// Each bus phase is held until the scheduler grants it. While no phase is
// active the port parks its address on IDLE_ADDR, which lies outside every
// bank window, so no scheduler selects it.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake (req_ready == !full)
//   req_addr, req_delta       request payload
//   addr_out, data_out        bus address / write data (registered)
//   write_en_out              bus write strobe (registered)
//   data_in                   read data from scheduler, 1-cycle latency
//   grant                     scheduler selected this port this cycle
//   busy                      FSM active or queue non-empty
//   done_count                completed writes, wraps at 2^16
//   sat_flag                  sticky saturation flag (BRAM_RMW_SAT_ADD_EN only)
//
// Build option: define BRAM_RMW_SAT_ADD_EN for unsigned-saturating addition
// and the sat_flag output; otherwise the sum wraps modulo 2^DATA_WIDTH.
// ----------------------------------------------------------------------------
module bram_rmw_requester #(
    parameter int                    ADDR_WIDTH = 13,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] IDLE_ADDR  = {ADDR_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_delta,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  write_en_out,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  grant,
    output logic                  busy,
    output logic [15:0]           done_count
`ifdef BRAM_RMW_SAT_ADD_EN
    ,
    output logic                  sat_flag
`endif
);

    localparam int                PTR_W    = $clog2(FIFO_DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_REQ  = 2'd1,
        S_RD_WAIT = 2'd2,
        S_WR_REQ  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fifo_addr_q  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_delta_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q, rd_ptr_nx_s;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [DATA_WIDTH-1:0] cur_delta_q, cur_delta_d;
    logic [ADDR_WIDTH-1:0] addr_out_q, addr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_d, sum_s;
    logic                  we_q, we_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic [15:0]           done_q, done_d;
    logic                  push_s, pop_s;
`ifdef BRAM_RMW_SAT_ADD_EN
    logic                  sat_q, sat_d;
    logic                  carry_s;

    // Full-width add; the extra MSB is the carry out.
    function automatic logic [DATA_WIDTH:0] add_wide(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    assign carry_s  = add_wide(data_in, cur_delta_q) >> DATA_WIDTH;
    assign sum_s    = carry_s ? {DATA_WIDTH{1'b1}} : data_in + cur_delta_q;
    assign sat_flag = sat_q;
`else
    assign sum_s    = data_in + cur_delta_q;
`endif

    assign push_s       = req_valid && ready_q;
    assign rd_ptr_nx_s  = rd_ptr_q + PTR_W'(1);
    assign req_ready    = ready_q;
    assign addr_out     = addr_out_q;
    assign data_out     = data_out_q;
    assign write_en_out = we_q;
    assign busy         = busy_q;
    assign done_count   = done_q;

    // Queue storage: written at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_addr_q[wr_ptr_q]  <= req_addr;
            fifo_delta_q[wr_ptr_q] <= req_delta;
        end
    end

    // Next-state, queue occupancy and next-output logic.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        cur_delta_d = cur_delta_q;
        data_d      = data_out_q;
        done_d      = done_q;
        pop_s       = 1'b0;
`ifdef BRAM_RMW_SAT_ADD_EN
        sat_d       = sat_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (count_q != {CNT_W{1'b0}}) begin
                    cur_addr_d  = fifo_addr_q[rd_ptr_q];
                    cur_delta_d = fifo_delta_q[rd_ptr_q];
                    state_d     = S_RD_REQ;
                end else begin
                    state_d     = S_IDLE;
                end
            end
            S_RD_REQ: begin
                if (grant) begin
                    state_d = S_RD_WAIT;
                end else begin
                    state_d = S_RD_REQ;
                end
            end
            S_RD_WAIT: begin
                data_d  = sum_s;
`ifdef BRAM_RMW_SAT_ADD_EN
                sat_d   = sat_q | carry_s;
`endif
                state_d = S_WR_REQ;
            end
            S_WR_REQ: begin
                if (grant) begin
                    pop_s  = 1'b1;
                    done_d = done_q + 16'd1;
                    // The head stays queued until its write is granted, so the
                    // next request sits one slot behind it, or is the word
                    // being pushed this very cycle when only one entry remains.
                    if (count_q >= CNT_W'(2)) begin
                        cur_addr_d  = fifo_addr_q[rd_ptr_nx_s];
                        cur_delta_d = fifo_delta_q[rd_ptr_nx_s];
                        state_d     = S_RD_REQ;
                    end else if (push_s) begin
                        cur_addr_d  = req_addr;
                        cur_delta_d = req_delta;
                        state_d     = S_RD_REQ;
                    end else begin
                        state_d     = S_IDLE;
                    end
                end else begin
                    state_d = S_WR_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Bus outputs are registered from the state being entered, so they
        // line up exactly with the phase the FSM is in.
        addr_d  = (state_d == S_RD_REQ || state_d == S_WR_REQ) ? cur_addr_d : IDLE_ADDR;
        we_d    = (state_d == S_WR_REQ);
        ready_d = (count_d != FULL_CNT);
        busy_d  = (state_d != S_IDLE) || (count_d != {CNT_W{1'b0}});
    end

    // State, pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            cur_addr_q  <= IDLE_ADDR;
            cur_delta_q <= {DATA_WIDTH{1'b0}};
            addr_out_q  <= IDLE_ADDR;
            data_out_q  <= {DATA_WIDTH{1'b0}};
            we_q        <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 16'd0;
`ifdef BRAM_RMW_SAT_ADD_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
            rd_ptr_q    <= pop_s ? rd_ptr_nx_s : rd_ptr_q;
            count_q     <= count_d;
            cur_addr_q  <= cur_addr_d;
            cur_delta_q <= cur_delta_d;
            addr_out_q  <= addr_d;
            data_out_q  <= data_d;
            we_q        <= we_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef BRAM_RMW_SAT_ADD_EN
            sat_q       <= sat_d;
`endif
        end
    end

endmodule

// File: tb/tb_bram_rmw_requester.sv
// ----------------------------------------------------------------------------
// tb_bram_rmw_requester
// Bench for bram_rmw_requester: a BRAM model answers granted bus phases, and a
// reference keeps the expected memory image and the expected write stream
// (address, value) in request-acceptance order.
// ----------------------------------------------------------------------------
module tb_bram_rmw_requester;

    localparam logic [12:0] IDLE = 13'h1FFF;
`ifdef BRAM_RMW_SAT_ADD_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [12:0] req_addr = 13'd0;
    logic [31:0] req_delta = 32'd0;
    logic [12:0] addr_out;
    logic [31:0] data_out;
    logic        write_en_out;
    logic [31:0] data_in = 32'd0;
    logic        grant = 1'b0;
    logic        busy;
    logic [15:0] done_count;
`ifdef BRAM_RMW_SAT_ADD_EN
    logic        sat_flag;
`endif

    bram_rmw_requester dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_delta    (req_delta),
        .addr_out     (addr_out),
        .data_out     (data_out),
        .write_en_out (write_en_out),
        .data_in      (data_in),
        .grant        (grant),
        .busy         (busy),
        .done_count   (done_count)
`ifdef BRAM_RMW_SAT_ADD_EN
        ,
        .sat_flag     (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          acc   = 0;   // requests accepted since reset
    int          wr    = 0;   // writes committed since reset
    logic [31:0] mem     [8192];
    logic [31:0] ref_mem [8192];
    logic [12:0] exp_a [$];
    logic [31:0] exp_d [$];

    typedef struct {
        logic [12:0] addr;
        logic [31:0] delta;
        logic [31:0] init;
        logic [31:0] expv;
    } vec_t;
    vec_t vecs [6];

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        w = {1'b0, a} + {1'b0, b};
        if (SAT_EN && w[32]) return 32'hFFFF_FFFF;
        return w[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // One clock: score what the edge commits, advance, then check the
    // occupancy-derived outputs against the reference counts.
    task automatic step();
        logic        rst_c, acc_c, wr_c, rd_c;
        logic [12:0] a;
        logic [31:0] d;
        rst_c = rst;
        acc_c = !rst && req_valid && req_ready;
        wr_c  = !rst && grant && write_en_out;
        rd_c  = !rst && grant && !write_en_out && (addr_out != IDLE);
        a = addr_out;
        d = data_out;
        if (wr_c) begin
            if (exp_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_unexpected: write addr %h data %h with nothing queued", a, d);
            end else begin
                chk("wr_addr", 32'(a), 32'(exp_a.pop_front()));
                chk("wr_data", d, exp_d.pop_front());
            end
            mem[a] = d;
            wr++;
        end
        if (acc_c) begin
            ref_mem[req_addr] = ref_add(ref_mem[req_addr], req_delta);
            exp_a.push_back(req_addr);
            exp_d.push_back(ref_mem[req_addr]);
            acc++;
        end
        @(posedge clk);
        #1;
        if (rd_c) data_in = mem[a];
        if (rst_c) begin
            acc = 0;
            wr  = 0;
            exp_a.delete();
            exp_d.delete();
            ref_mem = mem;
        end
        chk("req_ready", 32'(req_ready), 32'((acc - wr) != 4));
        chk("busy", 32'(busy), 32'(acc != wr));
        chk("done_count", 32'(done_count), 32'(wr[15:0]));
    endtask

    task automatic push1(input logic [12:0] a, input logic [31:0] dl);
        req_valid = 1'b1;
        req_addr  = a;
        req_delta = dl;
        step();
        req_valid = 1'b0;
    endtask

    // Run with the scheduler granting whenever the port is active.
    task automatic run_until_writes(input int target, input int budget);
        for (int i = 0; i < budget && wr < target; i++) begin
            grant = (addr_out != IDLE);
            step();
        end
        grant = 1'b0;
        chk("writes_reached", 32'(wr), 32'(target));
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) begin
            mem[i]     = 32'd0;
            ref_mem[i] = 32'd0;
        end
        vecs[0] = '{13'd5,    32'd3,          32'd10,         32'd13};
        vecs[1] = '{13'd0,    32'd0,          32'd0,          32'd0};
        vecs[2] = '{13'd100,  32'd2,          32'hFFFF_FFFF,  SAT_EN ? 32'hFFFF_FFFF : 32'h0000_0001};
        vecs[3] = '{13'd12,   32'h8000_0000,  32'h8000_0000,  SAT_EN ? 32'hFFFF_FFFF : 32'h0000_0000};
        vecs[4] = '{13'd8190, 32'd1,          32'd41,         32'd42};
        vecs[5] = '{13'd63,   32'hFFFF_FFFF,  32'd1,          SAT_EN ? 32'hFFFF_FFFF : 32'h0000_0000};

        // Reset state.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_addr", 32'(addr_out), 32'(IDLE));
        chk("rst_we", 32'(write_en_out), 32'd0);
        chk("rst_data", data_out, 32'd0);
`ifdef BRAM_RMW_SAT_ADD_EN
        chk("rst_sat", 32'(sat_flag), 32'd0);
`endif

        // Single requests with continuous grant, phase by phase.
        for (int i = 0; i < 6; i++) begin
            mem[vecs[i].addr]     = vecs[i].init;
            ref_mem[vecs[i].addr] = vecs[i].init;
            grant = 1'b0;
            push1(vecs[i].addr, vecs[i].delta);
            step();
            chk("rdreq_addr", 32'(addr_out), 32'(vecs[i].addr));
            chk("rdreq_we", 32'(write_en_out), 32'd0);
            grant = 1'b1;
            step();
            chk("rdwait_addr", 32'(addr_out), 32'(IDLE));
            chk("rdwait_we", 32'(write_en_out), 32'd0);
            step();
            chk("wr_we", 32'(write_en_out), 32'd1);
            chk("wr_addr_phase", 32'(addr_out), 32'(vecs[i].addr));
            chk("vec_sum", data_out, vecs[i].expv);
            step();
            grant = 1'b0;
            chk("after_wr_we", 32'(write_en_out), 32'd0);
            chk("after_wr_addr", 32'(addr_out), 32'(IDLE));
        end
`ifdef BRAM_RMW_SAT_ADD_EN
        chk("sat_flag", 32'(sat_flag), 32'd1);
`endif

        // Conflict stall: 4 denied cycles in RD_REQ, 2 in WR_REQ.
        mem[20] = 32'd5;
        ref_mem[20] = 32'd5;
        push1(13'd20, 32'd7);
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_rd_addr", 32'(addr_out), 32'd20);
            chk("stall_rd_we", 32'(write_en_out), 32'd0);
        end
        grant = 1'b1;
        step();
        grant = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_wr_we", 32'(write_en_out), 32'd1);
            chk("stall_wr_addr", 32'(addr_out), 32'd20);
            chk("stall_wr_data", data_out, 32'd12);
        end
        grant = 1'b1;
        step();
        grant = 1'b0;
        chk("stall_one_write", 32'(mem[20]), 32'd12);

        // Fill the queue with the scheduler refusing everything.
        begin
            int base_acc;
            int base_wr;
            base_acc = acc;
            base_wr  = wr;
            for (int i = 0; i < 5; i++) begin
                req_valid = 1'b1;
                req_addr  = 13'(40 + i);
                req_delta = 32'(i + 1);
                step();
            end
            req_valid = 1'b0;
            chk("fill_accepted", 32'(acc - base_acc), 32'd4);
            chk("fill_ready_low", 32'(req_ready), 32'd0);
            run_until_writes(base_wr + 4, 60);
            chk("fill_done", 32'(done_count), 32'(base_wr + 4));
        end

        // Same-address pair, memory initially zero: writes 1 then 3.
        push1(13'd7, 32'd1);
        push1(13'd7, 32'd2);
        run_until_writes(wr + 2, 40);
        chk("same_addr_final", mem[7], 32'd3);

        // Reset while a write is pending and denied.
        push1(13'd30, 32'd4);
        step();
        grant = 1'b1;
        step();
        grant = 1'b0;
        push1(13'd31, 32'd9);
        chk("pre_rst_we", 32'(write_en_out), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_we", 32'(write_en_out), 32'd0);
        chk("midrst_addr", 32'(addr_out), 32'(IDLE));
        for (int i = 0; i < 4; i++) begin
            grant = 1'b1;
            step();
            chk("post_rst_no_write", 32'(write_en_out), 32'd0);
        end
        grant = 1'b0;
        chk("post_rst_mem", mem[30], 32'd0);

        // Random traffic against the reference.
        for (int i = 0; i < 1500; i++) begin
            req_valid = ($urandom_range(0, 1) == 1);
            req_addr  = 13'($urandom_range(0, 15));
            req_delta = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
            grant     = ($urandom_range(0, 9) < 7) && (addr_out != IDLE);
            step();
        end
        req_valid = 1'b0;
        run_until_writes(acc, 200);
        for (int i = 0; i < 16; i++) begin
            chk("final_mem", mem[i], ref_mem[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
